// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_pkg
// Purpose  : Shared types and constants for the instruction-memory loader.
// Revision : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

    // Loader sequencing states. CHK is only reachable when the checksum
    // trailer is compiled in.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_LOAD = 3'd2,
        ST_CHK  = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    // The header is one little-endian 32-bit word, the same shape as a payload word.
    localparam int HDR_BYTES      = 4;
    localparam int BYTES_PER_WORD = 4;

    // Byte-lane indices inside an assembled word (lane 0 = bits [7:0]).
    localparam logic [1:0] LANE0 = 2'd0;
    localparam logic [1:0] LANE1 = 2'd1;
    localparam logic [1:0] LANE2 = 2'd2;
    localparam logic [1:0] LANE3 = 2'd3;

endpackage : imem_loader_pkg
`default_nettype wire

// File: rtl/imem_loader_byte_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_byte_word_packer
// Purpose  : Collects bytes into little-endian 32-bit words. The first three
//            bytes are held in lane registers; the fourth byte completes the
//            word combinationally so the caller can register it on that edge.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader_byte_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [1:0]  lane,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  r_lane;
    logic [23:0] r_low;

    // Lane counter and low-byte storage; each accepted byte fills the current lane.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_lane <= LANE0;
            r_low  <= 24'd0;
        end else if (byte_valid) begin
            case (r_lane)
                LANE0:   r_low[7:0]   <= byte_data;
                LANE1:   r_low[15:8]  <= byte_data;
                LANE2:   r_low[23:16] <= byte_data;
                default: r_low        <= r_low;
            endcase
            r_lane <= r_lane + 2'd1;
        end
    end

    assign lane       = r_lane;
    assign word_valid = byte_valid && (r_lane == LANE3);
    assign word       = {byte_data, r_low};

endmodule : imem_loader_byte_word_packer
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Loads a program image from a byte stream into the instruction
//            memory write port and holds the CPU in reset until the image is
//            complete. Stream format: 4-byte little-endian word count N, then
//            N little-endian words.
// Options  : IMEM_LOADER_CHECKSUM_EN - appends a one-byte XOR checksum of the
//            payload, verified in the CHK state before releasing the CPU.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          s_valid,
    input  logic [7:0]    s_data,
    output logic          s_ready,
    output logic          imem_we,
    output logic [31:0]   imem_wa,
    output logic [31:0]   imem_wd,
    output logic          cpu_reset,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW:0]   words_loaded
);

    localparam logic [1:0] c_HDR_LAST_LANE = 2'(HDR_BYTES - 1);

    // State entered once the payload (or an empty image) has been consumed.
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t c_POST_LOAD = ST_CHK;
`else
    localparam state_t c_POST_LOAD = ST_DONE;
`endif

    state_t       r_state;
    state_t       w_state_nxt;

    logic         w_fire;
    logic         w_arm;
    logic [1:0]   w_lane;
    logic         w_word_valid;
    logic [31:0]  w_word;
    logic         w_hdr_word;
    logic         w_pay_word;
    logic         w_last_word;
    logic [AW:0]  w_wl_inc;

    logic         r_we;
    logic [31:0]  r_wa;
    logic [31:0]  r_wd;
    logic [AW:0]  r_words_loaded;
    logic [AW:0]  r_count;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]   r_csum;
`endif

    // Ready depends on state only, so the upstream source never sees a loop.
    assign s_ready = (r_state == ST_HDR) || (r_state == ST_LOAD) || (r_state == ST_CHK);
    assign busy    = s_ready;
    assign w_fire  = s_valid && s_ready;

    // A new load is armed only from the resting states; start while busy is dropped.
    assign w_arm = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR));

    imem_loader_byte_word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (w_arm),
        .byte_valid (w_fire),
        .byte_data  (s_data),
        .lane       (w_lane),
        .word_valid (w_word_valid),
        .word       (w_word)
    );

    assign w_hdr_word  = (r_state == ST_HDR) && w_fire && (w_lane == c_HDR_LAST_LANE);
    assign w_pay_word  = (r_state == ST_LOAD) && w_word_valid;
    assign w_wl_inc    = r_words_loaded + {{AW{1'b0}}, 1'b1};
    assign w_last_word = w_pay_word && (w_wl_inc == r_count);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and status outputs.
    always_comb begin
        w_state_nxt = r_state;
        cpu_reset   = 1'b1;
        done        = 1'b0;
        err         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_HDR;
            end
            ST_HDR: begin
                if (w_hdr_word) begin
                    if (w_word == 32'd0) begin
                        w_state_nxt = c_POST_LOAD;
                    end else if (w_word > 32'(DEPTH)) begin
                        w_state_nxt = ST_ERR;
                    end else begin
                        w_state_nxt = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (w_last_word) w_state_nxt = c_POST_LOAD;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (w_fire) begin
                    w_state_nxt = (s_data == r_csum) ? ST_DONE : ST_ERR;
                end
            end
`endif
            ST_DONE: begin
                done      = 1'b1;
                cpu_reset = 1'b0;
                if (start) w_state_nxt = ST_HDR;
            end
            ST_ERR: begin
                err = 1'b1;
                if (start) w_state_nxt = ST_HDR;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Word count capture, memory write port and words_loaded tracking.
    // A completed payload word is written on the edge after its 4th byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we           <= 1'b0;
            r_wa           <= 32'd0;
            r_wd           <= 32'd0;
            r_words_loaded <= '0;
            r_count        <= '0;
        end else begin
            r_we <= 1'b0;
            if (w_arm) begin
                r_words_loaded <= '0;
            end
            if (w_hdr_word) begin
                r_count <= w_word[AW:0];
            end
            if (w_pay_word) begin
                r_we           <= 1'b1;
                r_wa           <= 32'(r_words_loaded[AW-1:0]) * 32'(BYTES_PER_WORD);
                r_wd           <= w_word;
                r_words_loaded <= w_wl_inc;
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running XOR over payload bytes only; header and trailer bytes excluded.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_csum <= 8'd0;
        end else if (w_arm) begin
            r_csum <= 8'd0;
        end else if ((r_state == ST_LOAD) && w_fire) begin
            r_csum <= r_csum ^ s_data;
        end
    end
`endif

    assign imem_we      = r_we;
    assign imem_wa      = r_wa;
    assign imem_wd      = r_wd;
    assign words_loaded = r_words_loaded;

endmodule : imem_loader
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Purpose  : Self-checking bench for imem_loader. Expected words, addresses,
//            checksums and final status are computed from the stream format.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int DEPTH = 64;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          s_valid;
    logic [7:0]    s_data;
    logic          s_ready;
    logic          imem_we;
    logic [31:0]   imem_wa;
    logic [31:0]   imem_wd;
    logic          cpu_reset;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW:0]   words_loaded;

    int checks   = 0;
    int errors   = 0;
    int wr_count = 0;
    int wr_base  = 0;
    logic [7:0] pay [0:255];
    logic [7:0] exp_csum;

    imem_loader #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .imem_we      (imem_we),
        .imem_wa      (imem_wa),
        .imem_wd      (imem_wd),
        .cpu_reset    (cpu_reset),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Count every write pulse seen by the memory.
    always @(negedge clk) begin
        if (imem_we === 1'b1) wr_count++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int k);
        return {pay[4*k+3], pay[4*k+2], pay[4*k+1], pay[4*k]};
    endfunction

    // Offer one byte after an optional idle gap; returns at the negedge after acceptance.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard;
        s_valid = 1'b0;
        repeat (gap) begin
            s_data = 8'($urandom);
            @(negedge clk);
        end
        s_valid = 1'b1;
        s_data  = b;
        guard   = 0;
        while (s_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("s_ready_timeout", {31'd0, s_ready}, 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
        s_data  = 8'($urandom);
    endtask

    // Start pulse, header, payload words from pay[]; checks each write as it happens.
    task automatic do_load(input logic [31:0] hdr, input int maxgap, input int start_at);
        int n;
        n = (hdr > 32'(DEPTH)) ? 0 : int'(hdr);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("arm_busy",      {31'd0, busy},      32'd1);
        check("arm_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("arm_done",      {31'd0, done},      32'd0);
        check("arm_err",       {31'd0, err},       32'd0);
        check("arm_wl",        32'(words_loaded),  32'd0);
        wr_base  = wr_count;
        exp_csum = 8'd0;
        for (int i = 0; i < 4; i++) send_byte(hdr[8*i +: 8], $urandom_range(0, maxgap));
        for (int i = 0; i < 4 * n; i++) begin
            if (i == start_at) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            send_byte(pay[i], $urandom_range(0, maxgap));
            exp_csum = exp_csum ^ pay[i];
            if (i % 4 == 3) begin
                check("we_pulse", {31'd0, imem_we}, 32'd1);
                check("wa",       imem_wa,          32'((i / 4) * 4));
                check("wd",       imem_wd,          exp_word(i / 4));
                check("wl_step",  32'(words_loaded), 32'(i / 4 + 1));
            end
        end
    endtask

    task automatic check_status(input logic exp_ok, input int exp_wl, input int exp_writes);
        @(negedge clk);
        #1;
        check("done",      {31'd0, done},      {31'd0, exp_ok});
        check("err",       {31'd0, err},       {31'd0, !exp_ok});
        check("cpu_reset", {31'd0, cpu_reset}, {31'd0, !exp_ok});
        check("busy_end",  {31'd0, busy},      32'd0);
        check("ready_end", {31'd0, s_ready},   32'd0);
        check("wl_end",    32'(words_loaded),  32'(exp_wl));
        check("writes",    32'(wr_count - wr_base), 32'(exp_writes));
    endtask

    // Complete load with a correct trailer when the checksum option is built in.
    task automatic run(input logic [31:0] hdr, input int maxgap, input int start_at);
        logic valid;
        int   n;
        valid = (hdr <= 32'(DEPTH));
        n     = valid ? int'(hdr) : 0;
        do_load(hdr, maxgap, start_at);
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (valid) send_byte(exp_csum, $urandom_range(0, maxgap));
`endif
        check_status(valid, n, n);
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic run_bad_chk(input logic [31:0] hdr, input logic [7:0] delta);
        do_load(hdr, 0, -1);
        send_byte(exp_csum ^ delta, 0);
        check_status(1'b0, int'(hdr), int'(hdr));
    endtask
`endif

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'd0;
        repeat (3) @(negedge clk);

        // Reset values.
        check("rst_s_ready",   {31'd0, s_ready},   32'd0);
        check("rst_we",        {31'd0, imem_we},   32'd0);
        check("rst_wa",        imem_wa,            32'd0);
        check("rst_wd",        imem_wd,            32'd0);
        check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_done",      {31'd0, done},      32'd0);
        check("rst_err",       {31'd0, err},       32'd0);
        check("rst_wl",        32'(words_loaded),  32'd0);
        reset = 1'b0;

        // Bytes offered while idle are refused.
        s_valid = 1'b1;
        s_data  = 8'hA5;
        repeat (2) begin
            @(negedge clk);
            check("idle_ready", {31'd0, s_ready}, 32'd0);
            check("idle_busy",  {31'd0, busy},    32'd0);
        end
        s_valid = 1'b0;

        // Two-word directed image.
        {pay[3], pay[2], pay[1], pay[0]} = 32'hE3A00001;
        {pay[7], pay[6], pay[5], pay[4]} = 32'hE3A01002;
        run(32'd2, 0, -1);

        // Oversized count and a huge count both abort in the header.
        run(32'd65, 0, -1);
        run(32'h8000_0000 | 32'($urandom), 1, -1);

        // Empty image.
        run(32'd0, 0, -1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        run_bad_chk(32'd0, 8'h5A);
`endif

        // Single word with random gaps between bytes.
        {pay[3], pay[2], pay[1], pay[0]} = 32'hE12FFF1E;
        run(32'd1, 3, -1);

        // Full-depth image with random data; a start pulse mid-load must be ignored.
        for (int i = 0; i < 256; i++) pay[i] = 8'($urandom);
        run(32'(DEPTH), 2, 101);

        // Assorted small random images.
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 32; i++) pay[i] = 8'($urandom);
            run(32'($urandom_range(1, 8)), 2, -1);
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
        run(32'd1, 0, -1);
        run_bad_chk(32'd1, 8'h01);
`endif

        // Reset after 6 of 8 payload bytes: word 0 stays written, nothing more.
        for (int i = 0; i < 8; i++) pay[i] = 8'($urandom);
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        wr_base = wr_count;
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 6; i++) begin
            send_byte(pay[i], 0);
            if (i == 3) check("mid_wd", imem_wd, exp_word(0));
        end
        reset = 1'b1;
        @(negedge clk);
        check("mid_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("mid_busy",      {31'd0, busy},      32'd0);
        check("mid_ready",     {31'd0, s_ready},   32'd0);
        check("mid_wl",        32'(words_loaded),  32'd0);
        check("mid_we",        {31'd0, imem_we},   32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("mid_writes",    32'(wr_count - wr_base), 32'd1);
        check("mid_idle_done", {31'd0, done},      32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_imem_loader
`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart to the instruction memory's asynchronous read port.
- Accepts a byte stream from a host link (UART RX or debug FIFO) over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Drives the memory's write port (we/wa/wd) and holds the CPU in reset until the program image is fully loaded.

Parameters:
- DEPTH, 64, number of 32-bit instruction words in the target memory (power of two).
- AW, $clog2(DEPTH), word-index width; derived, not overridden.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; arms a new load
- s_valid  in  1  byte stream valid
- s_data  in  8  byte stream data
- s_ready  out  1  loader accepts a byte this cycle
- imem_we  out  1  instruction memory write enable (one-cycle pulse)
- imem_wa  out  32  byte address (word_index<<2, bits[1:0]=0)
- imem_wd  out  32  instruction word
- cpu_reset  out  1  hold CPU in reset while high
- busy  out  1  loading in progress (HDR/LOAD/CHK)
- done  out  1  load completed successfully; sticky until next start/reset
- err  out  1  load aborted; sticky until next start/reset
- words_loaded  out  AW+1  count of words written this load

Behaviour:
- Reset values:
  - s_ready=0, imem_we=0, imem_wa=0, imem_wd=0.
  - cpu_reset=1, busy=0, done=0, err=0, words_loaded=0.
  - State IDLE, byte counter 0.
- Handshake: a byte transfers when s_valid && s_ready. s_ready is high exactly in HDR, LOAD and CHK; it is combinational from state only, never from s_valid.
- Packing: little-endian; the 1st byte of each group goes to bits[7:0], the 4th to [31:24]. A 2-bit byte counter wraps 3->0 on the 4th accepted byte.
- States:
  - IDLE: cpu_reset=1. start -> HDR; clear done, err, words_loaded.
  - HDR: accept 4 bytes forming count N.
    - N==0 -> DONE.
    - N>DEPTH -> ERR.
    - Else -> LOAD.
  - LOAD: on each completed word, the next cycle asserts imem_we=1 with imem_wd=word and imem_wa=words_loaded<<2, then increments words_loaded (write latency: 1 cycle after the 4th byte).
    - After the N-th write -> DONE, or CHK when the feature is enabled.
  - CHK: see Optional Feature.
  - DONE: done=1, cpu_reset=0, s_ready=0. start -> HDR and cpu_reset returns to 1 in the same transition.
  - ERR: err=1, cpu_reset=1, s_ready=0. start -> HDR.
- start while busy is ignored. Bytes offered in IDLE/DONE/ERR are not accepted (s_ready=0).
- Back-to-back bytes every cycle are sustained; no bubbles are required. The write of word k may coincide with acceptance of a byte of word k+1.
- The address never wraps: N<=DEPTH is guaranteed by the HDR check.
- Reset mid-load: returns to IDLE next edge with all outputs at reset values. Words already written remain in memory; no cleanup.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- With it defined:
  - An 8-bit running XOR of all payload bytes (not header bytes) is kept.
  - After the N-th word, CHK accepts one byte. Equal to the running XOR -> DONE; otherwise -> ERR.
  - With N==0, CHK expects 0x00.
- Without it: no CHK state and no checksum register; LOAD -> DONE directly.

Decomposition:
- Package imem_loader_pkg:
  - state enum (IDLE, HDR, LOAD, CHK, DONE, ERR)
  - HDR_BYTES=4, BYTES_PER_WORD=4
  - byte-lane index constants
- Sub-module byte_word_packer: byte-in valid/accept, 2-bit lane counter, 32-bit shift/lane register, word_valid pulse on 4th byte; reset-clearable.

Test Plan:
- reset, start, header 02 00 00 00, bytes 01 00 A0 E3 02 10 A0 E3 -> we at wa=0x0 wd=0xE3A00001, then wa=0x4 wd=0xE3A01002; words_loaded=2; done=1; cpu_reset falls.
- header 41 00 00 00 (N=65>DEPTH=64) -> ERR, err=1, s_ready=0, no imem_we pulse, cpu_reset stays 1.
- header 00 00 00 00 -> DONE immediately, no writes (with CHECKSUM_EN: send 00 -> done, send 5A -> err).
- N=1, s_valid toggled every other cycle with random gaps -> single write wd=0xE12FFF1E at wa=0; gaps do not corrupt lane order.
- reset asserted after 6 of 8 payload bytes -> next edge IDLE, cpu_reset=1, busy=0, words_loaded=0; word 0 already written, no further writes.
- CHECKSUM_EN, N=1 bytes 11 22 33 44, chk 44 -> done; repeat with chk 45 -> err, cpu_reset stays 1.
